fir_frame_capture: RTL and testbench
====================================

// Module: fir_frame_capture
// PURPOSE
//   Receive end of the FIR timing-strobe interface. Consumes the frame strobe
//   (filter_delay) and the DSP58 pipeline strobe (dsp58_delay) and checks their
//   spacing. On a correctly timed pipeline strobe it captures the accumulator
//   output, rounds and saturates it, and queues it in a 4-deep FIFO. Results
//   leave through a valid/ready handshake toward the downstream sample sink.
// PARAMETERS
//   DSP_LAT     3   cycles from frame_strobe to expected pipe_strobe (1..15)
//   ACC_W       48  accumulator input width, signed
//   OUT_W       16  output sample width, signed
//   FRAC_SHIFT  15  right shift applied before rounding (0..ACC_W-OUT_W)
//   FIFO_DEPTH  4   output queue depth (power of 2)
// PORTS
//   clk           in   1      system clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   frame_strobe  in   1      one-cycle pulse, start of filter frame
//   pipe_strobe   in   1      one-cycle pulse, DSP58 result valid
//   acc_in        in   ACC_W  signed accumulator, sampled when pipe_strobe=1
//   out_data      out  OUT_W  FIFO head sample
//   out_valid     out  1      FIFO non-empty
//   out_ready     in   1      sink accepts out_data when out_valid&out_ready
//   frame_cnt     out  16     count of good captures, wraps 0xFFFF->0
//   timing_err    out  1      sticky: strobe spacing violation
//   overflow      out  1      sticky: capture dropped because FIFO full
//   sat_flag      out  1      sticky: a sample was saturated
//   err_clr       in   1      synchronous clear of the three sticky flags
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, cnt=0, FIFO empty, out_valid=0,
//     out_data=0, frame_cnt=0, all sticky flags=0.
//   FSM, one register cnt[3:0]:
//   - IDLE: frame_strobe -> COUNT with cnt=1. pipe_strobe -> set timing_err
//     (stray strobe), no capture.
//   - COUNT: cnt increments each cycle. When the strobe arrives k cycles after
//     frame_strobe, cnt==k.
//     * pipe_strobe & cnt==DSP_LAT: capture, then IDLE.
//     * pipe_strobe & cnt!=DSP_LAT: timing_err=1, no capture, IDLE.
//     * cnt==DSP_LAT with no pipe_strobe: next cycle timing_err=1, IDLE (missed).
//     * frame_strobe while in COUNT: timing_err=1, restart with cnt=1.
//       A correct pipe_strobe in the same cycle is still captured first.
//   Capture arithmetic: t = acc_in >>> FRAC_SHIFT (arithmetic shift),
//     r = t + acc_in[FRAC_SHIFT-1] (round half up; no add when FRAC_SHIFT=0).
//     Compute r in ACC_W+1 bits. If r > 2^(OUT_W-1)-1 or r < -2^(OUT_W-1),
//     clamp to that limit and set sat_flag.
//   Capture to FIFO write: 1 cycle. The sample is visible on out_data/out_valid
//     the cycle after the pipe_strobe edge.
//   FIFO: first-word-fall-through. Pop on out_valid&out_ready.
//     Push when full: sample dropped, overflow=1, frame_cnt not incremented.
//     Push and pop in the same cycle when full: the pop frees a slot and the
//     push succeeds.
//   frame_cnt increments only on a successful push.
//   out_data holds its value while out_valid=1 & out_ready=0.
//   err_clr clears the sticky flags. If an error event occurs in the same
//     cycle, the flag stays set (set wins).
//   rst_n asserted mid-frame: FSM aborts, the FIFO is flushed, and no partial
//     capture is made.
// TESTING
//   1 frame_strobe@t0, pipe_strobe@t0+3, acc_in=0x0000_0001_8000 ->
//     out_data=0x0003, out_valid from t0+4, frame_cnt=1, no flags.
//   2 pipe_strobe@t0+2 after frame_strobe@t0 -> timing_err=1, FIFO empty;
//     then err_clr -> timing_err=0.
//   3 frame_strobe with no pipe_strobe -> timing_err=1 at t0+4, FSM back in IDLE.
//   4 acc_in=0x7FFF_FFFF_FFFF -> out_data=0x7FFF, sat_flag=1;
//     acc_in=-2^47 -> out_data=0x8000.
//   5 out_ready=0, six good frames -> 4 samples queued, overflow=1,
//     frame_cnt=4; drain returns samples in order.
//   6 rst_n pulsed low at t0+2 of a frame -> all outputs 0, no capture at t0+3.

Source files
------------

// File: rtl/fir_frame_capture.sv
// Receive side of the FIR timing-strobe interface: checks frame/pipe strobe spacing,
// captures, rounds and saturates the accumulator, and queues samples in a FWFT FIFO.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no frame open; a pipe strobe here is stray
// ST_COUNT| frame open, cnt = cycles since frame_strobe, awaiting pipe strobe
module fir_frame_capture #(
  parameter int DSP_LAT    = 3,
  parameter int ACC_W      = 48,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_strobe,
  input  logic             pipe_strobe,
  input  logic [ACC_W-1:0] acc_in,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      frame_cnt,
  output logic             timing_err,
  output logic             overflow,
  output logic             sat_flag,
  input  logic             err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAT4 = 4'(DSP_LAT);
  localparam logic signed [ACC_W:0] MAX_V = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MIN_V = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {ST_IDLE, ST_COUNT} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic capture, strobe_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    strobe_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pipe_strobe) strobe_err = 1'b1;
        if (frame_strobe) begin
          state_d = ST_COUNT;
          cnt_d   = 4'd1;
        end
      end
      ST_COUNT: begin
        if (pipe_strobe) begin
          if (cnt_q == LAT4) capture = 1'b1;
          else strobe_err = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == LAT4) begin
          strobe_err = 1'b1;
          state_d    = ST_IDLE;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
        // A well-timed pipe strobe is captured above before the restart.
        if (frame_strobe) begin
          strobe_err = 1'b1;
          state_d    = ST_COUNT;
          cnt_d      = 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  logic signed [ACC_W:0] acc_ext, shifted, rounded;
  logic sat_hi, sat_lo;
  logic [OUT_W-1:0] sample;

  assign acc_ext = {acc_in[ACC_W-1], acc_in};
  assign shifted = acc_ext >>> FRAC_SHIFT;

  generate
    if (FRAC_SHIFT == 0) begin : g_no_round
      assign rounded = shifted;
    end else begin : g_round
      assign rounded = shifted + $signed({{ACC_W{1'b0}}, acc_in[FRAC_SHIFT-1]});
    end
  endgenerate

  assign sat_hi = rounded > MAX_V;
  assign sat_lo = rounded < MIN_V;
  assign sample = sat_hi ? MAX_V[OUT_W-1:0] :
                  sat_lo ? MIN_V[OUT_W-1:0] : rounded[OUT_W-1:0];

  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
  logic [OUT_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic timing_err_q, timing_err_d, overflow_q, overflow_d, sat_flag_q, sat_flag_d;
  logic empty, full, pop, push, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push  = capture && (!full || pop);
  assign drop  = capture && full && !pop;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_cnt_d  = frame_cnt_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = sample;
      wr_ptr_d    = wr_ptr_q + 1'b1;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    timing_err_d = (timing_err_q && !err_clr) || strobe_err;
    overflow_d   = (overflow_q && !err_clr) || drop;
    sat_flag_d   = (sat_flag_q && !err_clr) || (capture && (sat_hi || sat_lo));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_cnt_q  <= 16'd0;
      timing_err_q <= 1'b0;
      overflow_q   <= 1'b0;
      sat_flag_q   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_cnt_q  <= frame_cnt_d;
      timing_err_q <= timing_err_d;
      overflow_q   <= overflow_d;
      sat_flag_q   <= sat_flag_d;
      mem_q        <= mem_d;
    end
  end

  assign out_valid  = !empty;
  assign out_data   = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign frame_cnt  = frame_cnt_q;
  assign timing_err = timing_err_q;
  assign overflow   = overflow_q;
  assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_fir_frame_capture.sv
// Randomized and directed bench for fir_frame_capture against a cycle-indexed
// event model (frame start time, sample queue, sticky flags).
module tb_fir_frame_capture;

  localparam int DSP_LAT    = 3;
  localparam int FRAC_SHIFT = 15;
  localparam int DEPTH      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_strobe = 1'b0;
  logic        pipe_strobe = 1'b0;
  logic [47:0] acc_in = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] frame_cnt;
  logic        timing_err, overflow, sat_flag;
  logic        err_clr = 1'b0;

  fir_frame_capture dut (
    .clk(clk), .rst_n(rst_n), .frame_strobe(frame_strobe), .pipe_strobe(pipe_strobe),
    .acc_in(acc_in), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_cnt(frame_cnt), .timing_err(timing_err), .overflow(overflow),
    .sat_flag(sat_flag), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic [15:0] m_q[$];
  int          pend = -1;
  int          cyc = 0;
  logic [15:0] m_fcnt = 0;
  bit          m_terr = 0, m_ovf = 0, m_sat = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] ref_sample(input logic [47:0] acc, output bit sat);
    longint a, r;
    a = $signed({{16{acc[47]}}, acc});
    r = (a >>> FRAC_SHIFT) + longint'(acc[FRAC_SHIFT-1]);
    sat = 1'b0;
    if (r > 32767) begin r = 32767; sat = 1'b1; end
    else if (r < -32768) begin r = -32768; sat = 1'b1; end
    return r[15:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    pend = -1;
    m_fcnt = 0;
    m_terr = 0; m_ovf = 0; m_sat = 0;
  endtask

  task automatic model_cycle(input bit fs, ps, input logic [47:0] acc, input bit rdy, clr);
    bit cap = 0, terr_ev = 0, ovf_ev = 0, sat_ev = 0, s;
    logic [15:0] smp;
    bit pop;
    int k;
    pop = (m_q.size() > 0) && rdy;
    if (pend < 0) begin
      if (ps) terr_ev = 1;
      if (fs) pend = cyc;
    end else begin
      k = cyc - pend;
      if (ps) begin
        if (k == DSP_LAT) cap = 1; else terr_ev = 1;
        pend = -1;
      end else if (k == DSP_LAT) begin
        terr_ev = 1;
        pend = -1;
      end
      if (fs) begin terr_ev = 1; pend = cyc; end
    end
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      smp = ref_sample(acc, s);
      sat_ev = s;
      if (m_q.size() < DEPTH) begin m_q.push_back(smp); m_fcnt++; end
      else ovf_ev = 1;
    end
    m_terr = (m_terr & !clr) | terr_ev;
    m_ovf  = (m_ovf & !clr) | ovf_ev;
    m_sat  = (m_sat & !clr) | sat_ev;
    cyc++;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".valid"}, out_valid, m_q.size() > 0);
    check_eq({tag, ".data"}, out_data, (m_q.size() > 0) ? m_q[0] : 16'h0);
    check_eq({tag, ".fcnt"}, frame_cnt, m_fcnt);
    check_eq({tag, ".terr"}, timing_err, m_terr);
    check_eq({tag, ".ovf"}, overflow, m_ovf);
    check_eq({tag, ".sat"}, sat_flag, m_sat);
  endtask

  task automatic step(input bit fs, ps, input logic [47:0] acc, input bit rdy, clr);
    frame_strobe = fs; pipe_strobe = ps; acc_in = acc; out_ready = rdy; err_clr = clr;
    model_cycle(fs, ps, acc, rdy, clr);
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    frame_strobe = 0; pipe_strobe = 0; out_ready = 0; err_clr = 0; acc_in = '0;
    #3;
    model_reset();
    check_outputs("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic good_frame(input logic [47:0] acc, input bit rdy);
    step(1, 0, '0, rdy, 0);
    for (int i = 1; i < DSP_LAT; i++) step(0, 0, '0, rdy, 0);
    step(0, 1, acc, rdy, 0);
  endtask

  function automatic logic [47:0] rand_acc();
    logic [30:0] v;
    case ($urandom_range(0, 3))
      0: return {16'($urandom), 32'($urandom)};
      1: begin v = 31'($urandom); return {{17{v[30]}}, v}; end
      2: return 48'($urandom_range(0, 1 << 20));
      default: return 48'(-longint'($urandom_range(0, 1 << 20)));
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [47:0] accs [6];
    bit s;
    bit fs, ps;

    apply_reset();

    // basic capture: 1.5 * 2 rounds to 3
    good_frame(48'h0000_0001_8000, 0);
    check_eq("t1_data", out_data, 16'h0003);
    check_eq("t1_valid", out_valid, 1'b1);
    check_eq("t1_fcnt", frame_cnt, 16'd1);
    check_eq("t1_flags", {timing_err, overflow, sat_flag}, 3'b000);
    step(0, 0, '0, 1, 0);
    check_eq("t1_drained", out_valid, 1'b0);

    // early pipe strobe
    step(1, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 1, 48'h1234, 1, 0);
    check_eq("t2_terr", timing_err, 1'b1);
    check_eq("t2_empty", out_valid, 1'b0);
    step(0, 0, '0, 1, 1);
    check_eq("t2_clr", timing_err, 1'b0);

    // missed pipe strobe
    step(1, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 1, 0);
    check_eq("t3_not_yet", timing_err, 1'b0);
    step(0, 0, '0, 1, 0);
    check_eq("t3_terr", timing_err, 1'b1);
    step(0, 1, 48'h1, 1, 1);
    check_eq("t3_idle_stray", timing_err, 1'b1);
    step(0, 0, '0, 1, 1);

    // saturation both ends
    good_frame(48'h7FFF_FFFF_FFFF, 0);
    check_eq("t4_pos", out_data, 16'h7FFF);
    check_eq("t4_sat", sat_flag, 1'b1);
    step(0, 0, '0, 1, 1);
    good_frame(48'h8000_0000_0000, 0);
    check_eq("t4_neg", out_data, 16'h8000);
    step(0, 0, '0, 1, 1);

    // overflow with sink stalled, then drain in order
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      accs[i] = 48'((i + 1) * 32768 * 7);
      good_frame(accs[i], 0);
    end
    check_eq("t5_fcnt", frame_cnt, 16'd4);
    check_eq("t5_ovf", overflow, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_eq("t5_order", out_data, ref_sample(accs[i], s));
      step(0, 0, '0, 1, 0);
    end
    check_eq("t5_empty", out_valid, 1'b0);

    // reset mid-frame, strobe afterwards is not captured
    step(1, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);
    rst_n = 1'b0;
    #3;
    model_reset();
    check_eq("t6_zero", {out_valid, out_data, frame_cnt, timing_err, overflow, sat_flag}, 32'h0);
    rst_n = 1'b1;
    step(0, 0, '0, 0, 0);
    step(0, 1, 48'h0000_0001_8000, 0, 0);
    check_eq("t6_nocap", out_valid, 1'b0);
    check_eq("t6_fcnt", frame_cnt, 16'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset();
      if (pend < 0) fs = ($urandom_range(0, 2) == 0);
      else fs = ($urandom_range(0, 19) == 0);
      if (pend >= 0 && (cyc - pend) == DSP_LAT) ps = ($urandom_range(0, 7) != 0);
      else ps = ($urandom_range(0, 15) == 0);
      step(fs, ps, rand_acc(), $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
